// File: rtl/jtkcpu_simctl_pkg.sv
// Shared constants and helpers for the simulation control block.
package jtkcpu_simctl_pkg;

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DLY_W  = 8;
    localparam int unsigned LFSR_W = 16;

    localparam logic [3:0] CS_HI_NIB   = 4'h1;
    localparam logic [3:0] CTRL_LO_NIB = 4'h0;
    localparam logic [3:0] ID_LO_NIB   = 4'h1;

    localparam int unsigned FINISH_DLY_DEF = 20;
    localparam int unsigned FIX_DLY_DEF    = 10;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    localparam int unsigned NMI_BIT    = 7;
    localparam int unsigned FIRQ_BIT   = 6;
    localparam int unsigned IRQ_BIT    = 5;
    localparam int unsigned GOOD_BIT   = 1;
    localparam int unsigned FINISH_BIT = 0;

    typedef struct packed {
        logic nmi;
        logic firq;
        logic irq;
    } irq_vec_t;

    // Right-shifting Galois step, taps 16,14,13,11
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/jtkcpu_simctl_lfsr.sv
// 16-bit Galois LFSR used to randomise the interrupt delay.
module jtkcpu_simctl_lfsr
    import jtkcpu_simctl_pkg::*;
(
    input  logic              clk,
    input  logic              load,
    input  logic              en,
    output logic [LFSR_W-1:0] state
);

    always_ff @(posedge clk) begin
        if (load)    state <= LFSR_SEED;
        else if (en) state <= lfsr_next(state);
    end

endmodule

// File: rtl/jtkcpu_simctl.sv
// Simulation control: finish/verdict register, delayed interrupt generator, ID readback.
// Define JTKCPU_SIMCTL_LFSR_EN for a pseudo-random interrupt delay instead of FIX_DLY.
module jtkcpu_simctl
    import jtkcpu_simctl_pkg::*;
#(
    parameter int unsigned FINISH_DLY = FINISH_DLY_DEF,
    parameter int unsigned FIX_DLY    = FIX_DLY_DEF
) (
    input  logic              rst,
    input  logic              clk,
    input  logic              cen2,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] dout,
    input  logic              we,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_hit,
    output logic              nmi_n,
    output logic              firq_n,
    output logic              irq_n,
    output logic              done,
    output logic              pass
);

    localparam int unsigned FIN_W = (FINISH_DLY < 2) ? 1 : $clog2(FINISH_DLY + 1);

    logic             ctrl_cs, id_cs, ctrl_wr;
    logic             good;
    irq_vec_t         rq;
    logic [FIN_W-1:0] fin_cnt;
    logic             fin_act;
    logic [DLY_W-1:0] dly_cnt, dly_val;
    logic             dly_act, dly_zero;
    logic             unused_bits;

    assign ctrl_cs     = (addr[15:12] == CS_HI_NIB) && (addr[3:0] == CTRL_LO_NIB);
    assign id_cs       = (addr[15:12] == CS_HI_NIB) && (addr[3:0] == ID_LO_NIB);
    assign ctrl_wr     = ctrl_cs && we;
    assign dly_zero    = dly_act && (dly_cnt == '0);
    assign unused_bits = ^{addr[11:4], dout[4:2]};

`ifdef JTKCPU_SIMCTL_LFSR_EN
    logic [LFSR_W-1:0] lfsr_q;
    logic              unused_lfsr;

    jtkcpu_simctl_lfsr u_lfsr (
        .clk   (clk),
        .load  (rst),
        .en    (cen2),
        .state (lfsr_q)
    );

    assign dly_val     = {lfsr_q[6:0], 1'b0};
    assign unused_lfsr = ^lfsr_q[15:7];
`else
    assign dly_val = DLY_W'(FIX_DLY);
`endif

    // Control register: sampled every clk, not gated by cen2
    always_ff @(posedge clk) begin
        if (rst) begin
            good <= 1'b0;
            rq   <= '0;
        end else if (ctrl_wr) begin
            good    <= dout[GOOD_BIT];
            rq.nmi  <= dout[NMI_BIT];
            rq.firq <= dout[FIRQ_BIT];
            rq.irq  <= dout[IRQ_BIT];
        end
    end

    // Finish countdown; done fires once when an active count reaches zero
    always_ff @(posedge clk) begin
        if (rst) begin
            fin_cnt <= '0;
            fin_act <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
        end else begin
            done <= 1'b0;
            pass <= 1'b0;
            if (ctrl_wr && dout[FINISH_BIT]) begin
                fin_cnt <= FIN_W'(FINISH_DLY);
                fin_act <= 1'b1;
            end else if (fin_cnt != '0) begin
                fin_cnt <= fin_cnt - FIN_W'(1);
            end else if (fin_act) begin
                done    <= 1'b1;
                pass    <= good;
                fin_act <= 1'b0;
            end
        end
    end

    // Interrupt delay counter, cen2 domain; a load beats expiry
    always_ff @(posedge clk) begin
        if (rst) begin
            dly_cnt <= '0;
            dly_act <= 1'b0;
        end else if (cen2) begin
            if (ctrl_wr) begin
                dly_cnt <= dly_val;
                dly_act <= 1'b1;
            end else if (dly_act) begin
                if (dly_cnt == '0) dly_act <= 1'b0;
                else               dly_cnt <= dly_cnt - DLY_W'(1);
            end
        end
    end

    // Interrupt lines: raised at delay expiry, held while requested
    always_ff @(posedge clk) begin
        if (rst) begin
            nmi_n  <= 1'b1;
            firq_n <= 1'b1;
            irq_n  <= 1'b1;
        end else if (cen2) begin
            nmi_n  <= ~(rq.nmi  && (~nmi_n  || dly_zero));
            firq_n <= ~(rq.firq && (~firq_n || dly_zero));
            irq_n  <= ~(rq.irq  && (~irq_n  || dly_zero));
        end
    end

    // ID readback, one clk latency
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
            rd_hit  <= 1'b0;
        end else begin
            rd_data <= id_cs ? addr[23:16] : '0;
            rd_hit  <= id_cs;
        end
    end

endmodule

// File: tb/tb_jtkcpu_simctl.sv
// Self-checking bench for jtkcpu_simctl; covers the LFSR delay when JTKCPU_SIMCTL_LFSR_EN is defined.
module tb_jtkcpu_simctl;

    localparam int FIN    = 20;
    localparam int FIX    = 10;
    localparam int BUDGET = 700;
    localparam logic [23:0] CTRL = 24'h001000;
    localparam logic [13:0] RST_OUTS = {3'b111, 3'b000, 8'h00};

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        cen2 = 1'b1;
    logic        we   = 1'b0;
    logic [23:0] addr = 24'h0;
    logic [7:0]  dout = 8'h0;
    logic [7:0]  rd_data;
    logic        rd_hit, nmi_n, firq_n, irq_n, done, pass;

    int n_cmp = 0;
    int n_err = 0;
    bit cen2_tog = 1'b0;
    logic [15:0] m_lfsr;
    int exp_q[$];
    logic [8:0] rd_q[$];

    jtkcpu_simctl dut (
        .rst(rst), .clk(clk), .cen2(cen2), .addr(addr), .dout(dout), .we(we),
        .rd_data(rd_data), .rd_hit(rd_hit), .nmi_n(nmi_n), .firq_n(firq_n),
        .irq_n(irq_n), .done(done), .pass(pass)
    );

    always #5 clk = ~clk;

    always @(negedge clk) cen2 <= cen2_tog ? ~cen2 : 1'b1;

    function automatic logic [15:0] galois(input logic [15:0] s);
        logic [15:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    // Reference LFSR: seeded in reset, steps on every cen2 clock
    always @(posedge clk) begin
        if (rst)       m_lfsr <= 16'hACE1;
        else if (cen2) m_lfsr <= galois(m_lfsr);
    end

    function automatic logic [13:0] outs();
        return {nmi_n, firq_n, irq_n, done, pass, rd_hit, rd_data};
    endfunction

    // One-clk write on a cen2=1 edge; returns the reference LFSR seen by that edge
    task automatic wr(input logic [23:0] a, input logic [7:0] d, output logic [15:0] lf);
        @(negedge clk); #1;
        while (cen2 !== 1'b1) begin @(negedge clk); #1; end
        addr = a; dout = d; we = 1'b1;
        lf = m_lfsr;
        @(negedge clk); #1;
        we = 1'b0; addr = 24'h0; dout = 8'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (outs() !== RST_OUTS) begin n_err++; $display("FAIL reset_hold: got %h want %h", outs(), RST_OUTS); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (outs() !== RST_OUTS) begin n_err++; $display("FAIL reset_release: got %h want %h", outs(), RST_OUTS); end
    endtask

    task automatic test_irq_fixed();
        logic [15:0] lf;
        int k, e;
        bit others_ok;
        wr(CTRL, 8'h20, lf);
        exp_q.push_back(FIX + 1);
        k = 0; others_ok = 1'b1;
        for (int i = 1; i <= BUDGET; i++) begin
            @(negedge clk);
            if (!nmi_n || !firq_n) others_ok = 1'b0;
            if (!irq_n) begin k = i; break; end
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (k != e) begin n_err++; $display("FAIL irq_latency: got %0d want %0d", k, e); end
        n_cmp++;
        if (!others_ok) begin n_err++; $display("FAIL irq_others: got asserted want 1"); end
        wr(CTRL, 8'h00, lf);
        n_cmp++;
        if (irq_n !== 1'b0) begin n_err++; $display("FAIL irq_clear_lag: got %b want 0", irq_n); end
        @(negedge clk);
        n_cmp++;
        if (irq_n !== 1'b1) begin n_err++; $display("FAIL irq_clear: got %b want 1", irq_n); end
    endtask

    task automatic test_finish();
        logic [15:0] lf;
        logic [7:0] d;
        int first, cnt, e;
        logic p;
        for (int t = 0; t < 2; t++) begin
            d = (t == 0) ? 8'h03 : 8'h01;
            wr(CTRL, d, lf);
            exp_q.push_back(FIN + 1);
            first = 0; cnt = 0; p = 1'bx;
            for (int i = 1; i <= FIN + 40; i++) begin
                @(negedge clk);
                if (done === 1'b1) begin
                    cnt++;
                    if (first == 0) begin first = i; p = pass; end
                end
            end
            e = exp_q.pop_front();
            n_cmp++;
            if (first != e) begin n_err++; $display("FAIL finish_latency[%0d]: got %0d want %0d", t, first, e); end
            n_cmp++;
            if (p !== d[1]) begin n_err++; $display("FAIL finish_pass[%0d]: got %b want %b", t, p, d[1]); end
            n_cmp++;
            if (cnt != 1) begin n_err++; $display("FAIL finish_pulses[%0d]: got %0d want 1", t, cnt); end
        end
    endtask

    task automatic test_read();
        logic [23:0] av[7];
        logic [8:0] e;
        av = '{24'h5A1001, 24'h5A1000, 24'hA51001, 24'h001001, 24'h123451, 24'hFF1FF1, 24'h000000};
        for (int i = 0; i <= 7; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = rd_q.pop_front();
                n_cmp++;
                if ({rd_hit, rd_data} !== e)
                    begin n_err++; $display("FAIL read[%0d]: got %b/%h want %b/%h", i - 1, rd_hit, rd_data, e[8], e[7:0]); end
            end
            if (i < 7) begin
                addr = av[i];
                if (av[i][15:12] == 4'h1 && av[i][3:0] == 4'h1) rd_q.push_back({1'b1, av[i][23:16]});
                else                                            rd_q.push_back(9'h000);
            end
        end
        addr = 24'h0;
    endtask

    task automatic test_rearm();
        logic [15:0] lf;
        int k, e;
        bit ok;
        wr(CTRL, 8'hE0, lf);
        exp_q.push_back(FIX + 1);
        k = 0;
        for (int i = 1; i <= BUDGET; i++) begin
            @(negedge clk);
            if ({nmi_n, firq_n, irq_n} === 3'b000) begin k = i; break; end
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (k != e) begin n_err++; $display("FAIL all_low_latency: got %0d want %0d", k, e); end
        wr(CTRL, 8'hE0, lf);
        ok = ({nmi_n, firq_n, irq_n} === 3'b000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if ({nmi_n, firq_n, irq_n} !== 3'b000) ok = 1'b0;
        end
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL hold_on_rewrite: got %b want 000", {nmi_n, firq_n, irq_n}); end
        wr(CTRL, 8'h00, lf);
        @(negedge clk);
        n_cmp++;
        if ({nmi_n, firq_n, irq_n} !== 3'b111) begin n_err++; $display("FAIL clear_all: got %b want 111", {nmi_n, firq_n, irq_n}); end
        wr(CTRL, 8'h80, lf);
        exp_q.push_back(FIX + 1);
        k = 0; ok = 1'b1;
        for (int i = 1; i <= BUDGET; i++) begin
            @(negedge clk);
            if (!firq_n || !irq_n) ok = 1'b0;
            if (!nmi_n) begin k = i; break; end
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (k != e) begin n_err++; $display("FAIL nmi_rearm_latency: got %0d want %0d", k, e); end
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL nmi_rearm_others: got asserted want 1"); end
        wr(CTRL, 8'h00, lf);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_id_write();
        logic [15:0] lf;
        bit quiet;
        wr(24'h001001, 8'hE3, lf);
        quiet = 1'b1;
        for (int i = 0; i < FIN + 20; i++) begin
            @(negedge clk);
            if (done || !nmi_n || !firq_n || !irq_n) quiet = 1'b0;
        end
        n_cmp++;
        if (!quiet) begin n_err++; $display("FAIL id_write_effect: got activity want none"); end
    endtask

    task automatic test_reset_abort();
        logic [15:0] lf;
        bit quiet;
        wr(CTRL, 8'h21, lf);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (outs() !== RST_OUTS) begin n_err++; $display("FAIL abort_in_reset: got %h want %h", outs(), RST_OUTS); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (outs() !== RST_OUTS) begin n_err++; $display("FAIL abort_release: got %h want %h", outs(), RST_OUTS); end
        quiet = 1'b1;
        for (int i = 0; i < FIN + 20; i++) begin
            @(negedge clk);
            if (outs() !== RST_OUTS) quiet = 1'b0;
        end
        n_cmp++;
        if (!quiet) begin n_err++; $display("FAIL abort_quiet: got %h want %h", outs(), RST_OUTS); end
    endtask

    task automatic test_delay();
        logic [15:0] lf;
        int ticks, e, obs, iters;
        bit found;
`ifdef JTKCPU_SIMCTL_LFSR_EN
        iters = 50;
`else
        iters = 6;
`endif
        cen2_tog = 1'b1;
        for (int n = 0; n < iters; n++) begin
            wr(CTRL, 8'h40, lf);
`ifdef JTKCPU_SIMCTL_LFSR_EN
            exp_q.push_back(int'({lf[6:0], 1'b0}));
`else
            exp_q.push_back(FIX);
`endif
            ticks = 0; found = 1'b0;
            for (int i = 0; i < BUDGET; i++) begin
                @(posedge clk);
                if (cen2) ticks++;
                #1;
                if (!firq_n) begin found = 1'b1; break; end
            end
            obs = found ? ticks - 1 : -1;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs != e) begin n_err++; $display("FAIL firq_delay[%0d]: got %0d want %0d", n, obs, e); end
            n_cmp++;
            if (obs < 0 || obs > 254 || (obs % 2) != 0)
                begin n_err++; $display("FAIL firq_delay_range[%0d]: got %0d want even 0..254", n, obs); end
            wr(CTRL, 8'h00, lf);
            repeat (4) @(negedge clk);
        end
        cen2_tog = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_irq_fixed();
        test_finish();
        test_read();
        test_rearm();
        test_id_write();
        test_reset_abort();
        test_delay();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
